// File: rtl/life_game_stepper.sv
// life_game_stepper
//   Computes one Game of Life generation (rule B3/S23, toroidal world,
//   64 columns x ROWS rows) on each accepted start request. The displayed
//   buffer of life_game_dev_io is read over the cell bus. The next
//   generation is written row by row into the hidden buffer. The displayed
//   buffer is then flipped through the select register at 7'h7F.
//
// Ports
//   clock          in   rising-edge clock
//   reset          in   asynchronous, active-high reset
//   start          in   one-cycle generation request, honoured only in IDLE
//   busy           out  high while a generation is in progress
//   done           out  one-cycle pulse after the flip cycle
//   generation     out  completed-generation count, wraps modulo 2^16
//   cell_write     out  write strobe to life_game_dev_io
//   cell_address   out  word address {row, half}; 7'h7F selects the buffer
//   cell_data_in   out  write data, 0 whenever cell_write is low
//   cell_data_out  in   combinational read data of the displayed buffer
module life_game_stepper #(
  parameter int ROWS = 48
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [15:0] generation,
  output logic        cell_write,
  output logic [6:0]  cell_address,
  output logic [31:0] cell_data_in,
  input  logic [31:0] cell_data_out
);

  localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);
  localparam logic [6:0] SEL_ADDR = 7'h7F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WR_LO,
    S_WR_HI,
    S_FETCH_LO,
    S_FETCH_HI,
    S_FLIP
  } state_t;

  state_t      r_state, w_state_d;
  logic [2:0]  r_cnt, w_cnt_d;
  logic [5:0]  r_y, w_y_d;
  logic        r_index, w_index_d;
  logic [63:0] r_prev, r_cur, r_next;
  logic [63:0] w_prev_d, w_cur_d, w_next_d;
  logic [63:0] w_life;
  logic        r_done, w_done_d;
  logic [15:0] r_gen, w_gen_d;
  logic        r_wr, w_wr_d;
  logic [6:0]  r_addr, w_addr_d;
  logic [31:0] r_din, w_din_d;

  // Row index after r, wrapping at the bottom of the torus.
  function automatic logic [5:0] f_next_row(input logic [5:0] r);
    return (r == LAST_ROW) ? 6'd0 : r + 6'd1;
  endfunction

  // Row read during each LOAD cycle: ROWS-1, then row 0, then row 1.
  function automatic logic [5:0] f_load_row(input logic [2:0] cnt);
    case (cnt[2:1])
      2'd0:    return LAST_ROW;
      2'd1:    return 6'd0;
      default: return f_next_row(6'd0);
    endcase
  endfunction

  // Next state of row c given its upper (p) and lower (n) neighbours.
  // Column indices are 6 bits wide, so x-1 and x+1 wrap modulo 64 naturally.
  function automatic logic [63:0] f_life(input logic [63:0] p,
                                         input logic [63:0] c,
                                         input logic [63:0] n);
    logic [63:0] res;
    logic [5:0]  xi, xl, xr;
    logic [3:0]  sum;
    res = '0;
    for (int x = 0; x < 64; x++) begin
      xi  = 6'(x);
      xl  = xi - 6'd1;
      xr  = xi + 6'd1;
      sum = 4'(p[xl]) + 4'(p[xi]) + 4'(p[xr]) + 4'(c[xl]) + 4'(c[xr]) +
            4'(n[xl]) + 4'(n[xi]) + 4'(n[xr]);
      res[xi] = (sum == 4'd3) || (c[xi] && (sum == 4'd2));
    end
    return res;
  endfunction

  // Row window update: reads land at the end of the cycle that drives the
  // address. The shift after WR_HI makes room for the next fetched row.
  always_comb begin
    w_prev_d = r_prev;
    w_cur_d  = r_cur;
    w_next_d = r_next;
    case (r_state)
      S_LOAD: begin
        case (r_cnt)
          3'd0:    w_prev_d[31:0]  = cell_data_out;
          3'd1:    w_prev_d[63:32] = cell_data_out;
          3'd2:    w_cur_d[31:0]   = cell_data_out;
          3'd3:    w_cur_d[63:32]  = cell_data_out;
          3'd4:    w_next_d[31:0]  = cell_data_out;
          default: w_next_d[63:32] = cell_data_out;
        endcase
      end
      S_FETCH_LO: w_next_d[31:0]  = cell_data_out;
      S_FETCH_HI: w_next_d[63:32] = cell_data_out;
      S_WR_HI: begin
        if (r_y != LAST_ROW) begin
          w_prev_d = r_cur;
          w_cur_d  = r_next;
        end
      end
      default: ;
    endcase
  end

  // Evaluated on the row values being loaded this edge, so the write data
  // can be registered on entry to WR_LO and WR_HI.
  assign w_life = f_life(w_prev_d, w_cur_d, w_next_d);

  // The bus outputs are registered, so this logic computes the address,
  // strobe and data for the state being entered.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_y_d     = r_y;
    w_index_d = r_index;
    w_gen_d   = r_gen;
    w_done_d  = 1'b0;
    w_wr_d    = 1'b0;
    w_addr_d  = 7'd0;
    w_din_d   = 32'd0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_d = S_LOAD;
          w_cnt_d   = 3'd0;
          w_y_d     = 6'd0;
          w_addr_d  = {f_load_row(3'd0), 1'b0};
        end
      end
      S_LOAD: begin
        if (r_cnt == 3'd5) begin
          w_state_d = S_WR_LO;
          w_wr_d    = 1'b1;
          w_addr_d  = {r_y, 1'b0};
          w_din_d   = w_life[31:0];
        end else begin
          w_cnt_d  = r_cnt + 3'd1;
          w_addr_d = {f_load_row(w_cnt_d), w_cnt_d[0]};
        end
      end
      S_WR_LO: begin
        w_state_d = S_WR_HI;
        w_wr_d    = 1'b1;
        w_addr_d  = {r_y, 1'b1};
        w_din_d   = w_life[63:32];
      end
      S_WR_HI: begin
        if (r_y == LAST_ROW) begin
          w_state_d = S_FLIP;
          w_wr_d    = 1'b1;
          w_addr_d  = SEL_ADDR;
          w_din_d   = {31'd0, ~r_index};
        end else begin
          w_state_d = S_FETCH_LO;
          w_y_d     = r_y + 6'd1;
          w_addr_d  = {f_next_row(w_y_d), 1'b0};
        end
      end
      S_FETCH_LO: begin
        w_state_d = S_FETCH_HI;
        w_addr_d  = {f_next_row(r_y), 1'b1};
      end
      S_FETCH_HI: begin
        w_state_d = S_WR_LO;
        w_wr_d    = 1'b1;
        w_addr_d  = {r_y, 1'b0};
        w_din_d   = w_life[31:0];
      end
      S_FLIP: begin
        w_state_d = S_IDLE;
        w_done_d  = 1'b1;
        w_gen_d   = r_gen + 16'd1;
        w_index_d = ~r_index;
      end
      default: w_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_y     <= 6'd0;
      r_index <= 1'b0;
      r_prev  <= '0;
      r_cur   <= '0;
      r_next  <= '0;
      r_done  <= 1'b0;
      r_gen   <= 16'd0;
      r_wr    <= 1'b0;
      r_addr  <= 7'd0;
      r_din   <= 32'd0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_y     <= w_y_d;
      r_index <= w_index_d;
      r_prev  <= w_prev_d;
      r_cur   <= w_cur_d;
      r_next  <= w_next_d;
      r_done  <= w_done_d;
      r_gen   <= w_gen_d;
      r_wr    <= w_wr_d;
      r_addr  <= w_addr_d;
      r_din   <= w_din_d;
    end
  end

  assign busy         = (r_state != S_IDLE);
  assign done         = r_done;
  assign generation   = r_gen;
  assign cell_write   = r_wr;
  assign cell_address = r_addr;
  assign cell_data_in = r_din;

endmodule
